// File: rtl/decode_job_arbiter_pkg.sv
// Shared decoder-link constants, arbiter state encoding and job size helpers.
package decode_job_arbiter_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HEADER,
    ARB_PAYLOAD,
    ARB_RESPONSE
  } arb_state_e;

  function automatic int ceil_div8(input int n);
    return (n + 7) / 8;
  endfunction

  // Bytes following the measurement header: per-round X and U syndrome bitmaps.
  function automatic int payload_bytes(input int gx, input int gz, input int gu);
    return gu * (ceil_div8(gx * gz) + ceil_div8(gu * gu - (gu - 1)));
  endfunction

  // Result frame: 3 status bytes plus one correction bitmap per round.
  function automatic int rsp_bytes(input int gx, input int gz, input int gu);
    int corr;
    corr = (gx - 1) * gz + (gx - 1) * gz + 1 + gx * gz;
    return 3 + gu * ceil_div8(corr);
  endfunction

endpackage

// File: rtl/decode_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (grant == '0 && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        grant_idx          = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/decode_job_arbiter.sv
// Shares one decoder controller between NUM_REQ host byte streams, one job at a time,
// with zero-latency pass-through and a response watchdog.
module decode_job_arbiter
  import decode_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GRID_WIDTH_X   = 4,
  parameter int GRID_WIDTH_Z   = 1,
  parameter int GRID_WIDTH_U   = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 dec_in_data,
  output logic                       dec_in_valid,
  input  logic                       dec_in_ready,
  input  logic [7:0]                 dec_out_data,
  input  logic                       dec_out_valid,
  output logic                       dec_out_ready,
  output logic [NUM_REQ*8-1:0]       rsp_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse,
  output logic [15:0]                drop_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PB = payload_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
  localparam int RB = rsp_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
  localparam int CW = $clog2(((PB > RB) ? PB : RB) + 1);

  arb_state_e         state;
  logic [IW-1:0]      last_grant;
  logic [CW-1:0]      byte_cnt;
  logic [31:0]        wdog;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               hdr_known;
  logic               in_hs;
  logic               out_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_idx  (pick_idx)
  );

  assign sel_data  = req_data[8*int'(grant_id) +: 8];
  assign sel_valid = req_valid[grant_id];
  assign hdr_known = (sel_data == MEASUREMENT_DATA_HEADER) || (sel_data == START_DECODING_MSG);
  assign in_hs     = dec_in_valid && dec_in_ready;
  assign out_hs    = dec_out_valid && dec_out_ready;
  assign busy      = (state != ARB_IDLE);

  // Routing: only the owner is ever connected; idle drains stray decoder bytes.
  always_comb begin
    req_ready     = '0;
    rsp_data      = '0;
    rsp_valid     = '0;
    dec_in_data   = 8'h00;
    dec_in_valid  = 1'b0;
    dec_out_ready = 1'b0;
    case (state)
      ARB_IDLE: dec_out_ready = dec_out_valid;
      ARB_HEADER: begin
        if (hdr_known) begin
          dec_in_data         = sel_data;
          dec_in_valid        = sel_valid;
          req_ready[grant_id] = dec_in_ready;
        end else begin
          req_ready[grant_id] = 1'b1;
        end
      end
      ARB_PAYLOAD: begin
        dec_in_data         = sel_data;
        dec_in_valid        = sel_valid;
        req_ready[grant_id] = dec_in_ready;
      end
      ARB_RESPONSE: begin
        rsp_data[8*int'(grant_id) +: 8] = dec_out_data;
        rsp_valid[grant_id]             = dec_out_valid;
        dec_out_ready                   = rsp_ready[grant_id];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      grant_id      <= '0;
      last_grant    <= IW'(NUM_REQ - 1);
      byte_cnt      <= '0;
      wdog          <= '0;
      drop_count    <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|pick) begin
            grant_id <= pick_idx;
            state    <= ARB_HEADER;
          end
        end
        ARB_HEADER: begin
          if (sel_valid) begin
            if (!hdr_known) begin
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
              last_grant <= grant_id;
              state      <= ARB_IDLE;
            end else if (dec_in_ready) begin
              if (sel_data == MEASUREMENT_DATA_HEADER) begin
                byte_cnt <= '0;
                state    <= ARB_PAYLOAD;
              end else begin
                last_grant <= grant_id;
                state      <= ARB_IDLE;
              end
            end
          end
        end
        ARB_PAYLOAD: begin
          if (in_hs) begin
            if (byte_cnt == CW'(PB - 1)) begin
              byte_cnt <= '0;
              wdog     <= '0;
              state    <= ARB_RESPONSE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ARB_RESPONSE: begin
          wdog <= wdog + 32'd1;
          if (out_hs && byte_cnt == CW'(RB - 1)) begin
            byte_cnt   <= '0;
            last_grant <= grant_id;
            state      <= ARB_IDLE;
          end else begin
            if (out_hs) byte_cnt <= byte_cnt + 1'b1;
            // A result frame that stalls past the limit frees the decoder for others.
            if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
              timeout_pulse <= 1'b1;
              byte_cnt      <= '0;
              last_grant    <= grant_id;
              state         <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
